// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial ripple adder. Computes {c_out, sum} = a + b + c_in
//               one bit per clock, LSB first, with a single full-adder cell
//               and a carry flop. Start/done handshake; the result is held
//               until the next operation completes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, sampled only while idle
//   a      in   WIDTH  operand A, captured on the accepted start
//   b      in   WIDTH  operand B, captured on the accepted start
//   c_in   in   1      carry-in, captured on the accepted start
//   busy   out  1      high while a request is in progress (RUN and DONE)
//   done   out  1      one-cycle pulse, sum/c_out valid from this cycle
//   sum    out  WIDTH  registered result, held until the next completion
//   c_out  out  1      registered carry-out, held until the next completion
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_a_q,  sh_a_d;
  logic [WIDTH-1:0] sh_b_q,  sh_b_d;
  logic             cy_q,    cy_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             c_out_q, c_out_d;

  // Single full-adder cell operating on the current LSBs and the carry flop.
  logic fa_s;
  logic fa_c;
  logic last_bit;

  always_comb begin
    fa_s     = sh_a_q[0] ^ sh_b_q[0] ^ cy_q;
    fa_c     = (sh_a_q[0] & sh_b_q[0]) | (sh_a_q[0] & cy_q) | (sh_b_q[0] & cy_q);
    last_bit = (cnt_q == CNT_LAST);
  end

  // --------------------------------------------------------------------------
  // Process 1: state and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  // --------------------------------------------------------------------------
  // Process 2: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next values. Everything holds unless the state says otherwise;
  // in particular start during RUN/DONE and operand changes after acceptance
  // never reach the shift registers.
  // --------------------------------------------------------------------------
  always_comb begin
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_a_d = a;
          sh_b_d = b;
          cy_d   = c_in;
          cnt_d  = '0;
          acc_d  = '0;
        end
      end
      S_RUN: begin
        sh_a_d = {1'b0, sh_a_q[WIDTH-1:1]};
        sh_b_d = {1'b0, sh_b_q[WIDTH-1:1]};
        cy_d   = fa_c;
        // Sum bits enter at the MSB, so after WIDTH shifts bit 0 holds the LSB.
        acc_d  = {fa_s, acc_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (last_bit) begin
          // Publish the completed word directly from the shifter input so the
          // visible result never shows a partial value.
          sum_d   = {fa_s, acc_q[WIDTH-1:1]};
          c_out_d = fa_c;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Process 3: outputs, decoded from registered state only
  // --------------------------------------------------------------------------
  always_comb begin
    busy  = (state_q == S_RUN) || (state_q == S_DONE);
    done  = (state_q == S_DONE);
    sum   = sum_q;
    c_out = c_out_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder. A WIDTH=8 instance runs
//               directed and randomized operations with cycle-exact handshake
//               checks; a WIDTH=4 instance is swept over every (a,b,c_in).
//               Expected results are queued at issue time and a monitor per
//               instance pops them when done is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- WIDTH = 8 instance ----------------
  logic       rst_n8 = 1'b0;
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       c8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n8), .start(start8), .a(a8), .b(b8), .c_in(c8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8)
  );

  // ---------------- WIDTH = 4 instance ----------------
  logic       rst_n4 = 1'b0;
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       c4 = 1'b0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n4), .start(start4), .a(a4), .b(b4), .c_in(c4),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4)
  );

  // Scoreboards: {c_out, sum} expected for each issued operation.
  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic [8:0] held8 = '0;
  logic [4:0] held4 = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- Monitors ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (done8) begin
      total++;
      if (q8.size() == 0) begin
        bad++;
        $display("FAIL w8_unexpected_done: got done=1 expected no pending op at %0t", $time);
      end else begin
        e = q8.pop_front();
        chk("w8_result", {23'd0, cout8, sum8}, {23'd0, e});
        held8 = e;
      end
    end else begin
      chk("w8_hold", {23'd0, cout8, sum8}, {23'd0, held8});
    end
  end

  always @(negedge clk) begin
    logic [4:0] e;
    if (done4) begin
      total++;
      if (q4.size() == 0) begin
        bad++;
        $display("FAIL w4_unexpected_done: got done=1 expected no pending op at %0t", $time);
      end else begin
        e = q4.pop_front();
        chk("w4_result", {27'd0, cout4, sum4}, {27'd0, e});
        held4 = e;
      end
    end else begin
      chk("w4_hold", {27'd0, cout4, sum4}, {27'd0, held4});
    end
  end

  // ---------------- WIDTH=8 operation with cycle-exact checks ----------------
  // inject: pulse start with 0xFF/0xFF at run cycle 3 (must be ignored)
  // abort : drop rst_n at run cycle 4
  // scramble: randomize operands every cycle while running
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input bit inject, input bit abort, input bit scramble);
    int waited = 0;
    @(posedge clk); #1;
    while (busy8 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    if (busy8) begin
      chk("w8_idle_timeout", 32'(busy8), 32'd0);
      return;
    end
    start8 = 1'b1; a8 = a; b8 = b; c8 = c;
    q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("w8_busy_accept", 32'(busy8), 32'd1);
    chk("w8_done_accept", 32'(done8), 32'd0);
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      chk("w8_busy_run", 32'(busy8), 32'd1);
      chk("w8_done_run", 32'(done8), 32'd0);
      if (scramble) begin
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      end
      if (inject && i == 3) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end
      if (inject && i == 4) start8 = 1'b0;
      if (abort && i == 4) begin
        rst_n8 = 1'b0;
        #1;
        chk("w8_abort_busy", 32'(busy8), 32'd0);
        chk("w8_abort_done", 32'(done8), 32'd0);
        chk("w8_abort_sum", {23'd0, cout8, sum8}, 32'd0);
        q8.delete();
        held8 = '0;
        @(posedge clk); #1;
        chk("w8_abort_idle", 32'(busy8), 32'd0);
        rst_n8 = 1'b1;
        return;
      end
    end
    @(posedge clk); #1;
    chk("w8_done_pulse", 32'(done8), 32'd1);
    chk("w8_busy_done", 32'(busy8), 32'd1);
    @(posedge clk); #1;
    chk("w8_done_clear", 32'(done8), 32'd0);
    chk("w8_busy_clear", 32'(busy8), 32'd0);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int waited = 0;
    @(posedge clk); #1;
    while (busy4 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    start4 = 1'b1; a4 = a; b4 = b; c4 = c;
    q4.push_back({1'b0, a} + {1'b0, b} + {4'd0, c});
    @(posedge clk); #1;
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
    waited = 0;
    while (!done4 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!done4) chk("w4_done_timeout", 32'(done4), 32'd1);
  endtask

  // ---------------- Stimulus ----------------
  initial begin
    #2;
    chk("w8_reset_busy", 32'(busy8), 32'd0);
    chk("w8_reset_done", 32'(done8), 32'd0);
    chk("w8_reset_sum", {23'd0, cout8, sum8}, 32'd0);
    chk("w4_reset_sum", {27'd0, cout4, sum4}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n8 = 1'b1;
    rst_n4 = 1'b1;

    // Directed cases
    op8(8'h00, 8'h00, 1'b0, 0, 0, 0);
    op8(8'hFF, 8'h01, 1'b0, 0, 0, 0);
    op8(8'h5A, 8'hA5, 1'b1, 0, 0, 0);
    op8(8'h3C, 8'h42, 1'b0, 0, 0, 0);
    op8(8'h10, 8'h20, 1'b0, 1, 0, 0);
    op8(8'h77, 8'h88, 1'b1, 0, 1, 0);
    op8(8'h01, 8'h02, 1'b0, 0, 0, 0);
    op8(8'hFF, 8'hFF, 1'b1, 0, 0, 1);

    // Randomized operations with operand churn while running
    for (int n = 0; n < 40; n++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), 0, 0, 1);

    // WIDTH=4 exhaustive sweep
    for (int v = 0; v < 512; v++)
      op4(v[3:0], v[7:4], v[8]);

    repeat (4) @(posedge clk);
    #1;
    chk("w8_queue_empty", 32'(q8.size()), 32'd0);
    chk("w4_queue_empty", 32'(q4.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
